clk_switch_n: RTL

Parametrised glitch-free clock multiplexer for N_CLK asynchronous clock sources, the multi-source successor to the two-input switch. Each channel owns an enable handshake, synchronised in its own clock domain and updated on that clock's falling edge. A new clock is never enabled until every other channel has observed its own disable. The block sits at the clock-generation boundary, ahead of the functional clock trees, with sel driven by quasi-static configuration logic.

---
 rtl/clk_switch_n_pkg.sv | 38 +++
 rtl/clk_switch_n_chan.sv | 83 ++++++++
 rtl/clk_switch_n.sv | 122 ++++++++++++
 3 files changed

// File: rtl/clk_switch_n_pkg.sv
// -----------------------------------------------------------------------------
// clk_switch_n_pkg
//
// Shared definitions for the N-input glitch-free clock switch.
//
//   CLK_SWITCH_N_MAX_CLK    largest supported number of source clocks
//   CLK_SWITCH_N_MAX_SYNC   largest supported synchroniser depth per channel
//   CLK_SWITCH_N_SEL_MAX_W  width of a select index at the largest N_CLK
//
//   clk_switch_n_sel_onehot(sel_idx, n_clk)
//     One-hot decode of a binary select index, always CLK_SWITCH_N_MAX_CLK
//     bits wide. An index >= n_clk decodes to all zeros, so an out-of-range
//     select requests no channel at all.
// -----------------------------------------------------------------------------
package clk_switch_n_pkg;

  localparam int CLK_SWITCH_N_MAX_CLK   = 16;
  localparam int CLK_SWITCH_N_MAX_SYNC  = 4;
  localparam int CLK_SWITCH_N_SEL_MAX_W = $clog2(CLK_SWITCH_N_MAX_CLK);

  // Per-channel vector at the largest supported channel count.
  typedef logic [CLK_SWITCH_N_MAX_CLK-1:0]   clk_switch_n_vec_t;
  // Select index at the largest supported channel count.
  typedef logic [CLK_SWITCH_N_SEL_MAX_W-1:0] clk_switch_n_sel_t;

  function automatic clk_switch_n_vec_t clk_switch_n_sel_onehot(
    input clk_switch_n_sel_t sel_idx,
    input int unsigned       n_clk
  );
    clk_switch_n_vec_t oh;
    oh = '0;
    if (32'(sel_idx) < n_clk) begin
      oh[sel_idx] = 1'b1;
    end
    return oh;
  endfunction

endpackage : clk_switch_n_pkg

// File: rtl/clk_switch_n_chan.sv
// -----------------------------------------------------------------------------
// clk_switch_n_chan
//
// One channel of the N-input clock switch. The channel's request is
// re-timed into its own clock domain by SYNC_STAGES rising-edge flops and
// then captured by a single falling-edge flop, the channel enable. Because
// the enable only moves on a falling edge of its own clock, gating that
// clock with the enable can never cut a high phase short or create a runt.
//
// Handshake: i_req is a level request from the top; o_en is the
// acknowledgement, following i_req after SYNC_STAGES rising edges plus one
// falling edge of i_clk. There is no back-pressure; the top only ever drops
// or raises i_req and observes o_en / o_occupied.
//
// Parameters
//   SYNC_STAGES  rising-edge synchroniser depth, 0..CLK_SWITCH_N_MAX_SYNC
//                (0 only when i_req is already related to i_clk)
//   RST_VAL      reset value of every flop in this channel
//
// Ports
//   i_clk       input   source clock of this channel
//   rst         input   asynchronous, active-low reset
//   i_req       input   request to enable this channel (asynchronous)
//   o_en        output  channel enable flop (falling-edge timed)
//   o_occupied  output  high while any flop of the channel holds a 1, i.e.
//                       the channel is enabled or an enable is in flight
// -----------------------------------------------------------------------------
module clk_switch_n_chan
  import clk_switch_n_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic rst,
  input  logic i_req,
  output logic o_en,
  output logic o_occupied
);

  logic w_sync_out;
  logic w_chain_any;
  logic r_en;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Plain shift chain: stage 0 samples the asynchronous request, the
      // remaining stages give metastability time before the enable flop.
      always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
          r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
          r_sync[0] <= i_req;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_sync_out  = r_sync[SYNC_STAGES-1];
      assign w_chain_any = |r_sync;
    end else begin : g_nosync
      // Related clocks: the request goes straight to the enable flop.
      assign w_sync_out  = i_req;
      assign w_chain_any = 1'b0;
    end
  endgenerate

  // Falling-edge enable: changes only while i_clk is low.
  always_ff @(negedge i_clk or negedge rst) begin
    if (!rst) begin
      r_en <= RST_VAL;
    end else begin
      r_en <= w_sync_out;
    end
  end

  assign o_en       = r_en;
  assign o_occupied = r_en | w_chain_any;

endmodule : clk_switch_n_chan

// File: rtl/clk_switch_n.sv
// -----------------------------------------------------------------------------
// clk_switch_n
//
// Glitch-free clock multiplexer for N_CLK mutually asynchronous sources.
// Each source owns a channel (clk_switch_n_chan) whose enable is timed in
// that source's own domain. A channel is only requested once every other
// channel has drained, so at most one enable is ever set and the output is
// held low for the (unbounded) gap between the old enable falling and the
// new one rising.
//
// Parameters
//   N_CLK        number of source clocks, 2..CLK_SWITCH_N_MAX_CLK
//   SYNC_STAGES  synchroniser depth per channel, 0..CLK_SWITCH_N_MAX_SYNC
//   SEL_W        derived select width, $clog2(N_CLK)
//
// Ports
//   clk        input   [N_CLK]  source clocks, bit i is channel i
//   rst        input   1        asynchronous, active-low reset
//   sel        input   [SEL_W]  binary index of the requested source;
//                               values >= N_CLK select nothing
//   clk_out    output  1        muxed clock
//   active_oh  output  [N_CLK]  channel enable flops (at most one set)
//   busy       output  1        high while active_oh differs from the
//                               one-hot decode of sel
//
// active_oh and busy are asynchronous status; synchronise before use.
//
// Build option: define CLK_SWITCH_N_DEFAULT_CH0_EN to make channel 0 come
// out of reset already enabled, so clk_out follows clk[0] during and right
// after reset. Without it, every channel resets disabled and clk_out is low.
// -----------------------------------------------------------------------------
module clk_switch_n
  import clk_switch_n_pkg::*;
#(
  parameter  int N_CLK       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = $clog2(N_CLK)
) (
  input  logic [N_CLK-1:0] clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  output logic             clk_out,
  output logic [N_CLK-1:0] active_oh,
  output logic             busy
);

`ifdef CLK_SWITCH_N_DEFAULT_CH0_EN
  localparam logic CH0_RST_VAL = 1'b1;
`else
  localparam logic CH0_RST_VAL = 1'b0;
`endif

  clk_switch_n_sel_t  w_sel_ext;
  clk_switch_n_vec_t  w_dec;
  clk_switch_n_vec_t  w_active_ext;
  logic [N_CLK-1:0]   w_req;
  logic [N_CLK-1:0]   w_en;
  logic [N_CLK-1:0]   w_occ;

  // ---------------------------------------------------------------------------
  // Select decode (zero when sel is out of range)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_ext            = '0;
    w_sel_ext[SEL_W-1:0] = sel;
  end

  assign w_dec = clk_switch_n_sel_onehot(w_sel_ext, N_CLK);

  // ---------------------------------------------------------------------------
  // Requests
  //
  // A channel is requested only when it is selected and no other channel is
  // occupied. "Occupied" covers the synchroniser chain as well as the enable:
  // if sel moves on while a request pulse is still travelling down one chain,
  // that pulse must finish (and drain) before any other channel may start,
  // otherwise two enables could rise from overlapping in-flight requests.
  // When a channel is enabled its chain is full of ones and empties before
  // the enable drops, so this adds no latency to an ordinary handoff.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_CLK; i++) begin
      w_req[i] = w_dec[i] & ~(|(w_occ & ~(N_CLK'(1) << i)));
    end
  end

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < N_CLK; i++) begin : g_chan
      clk_switch_n_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     ((i == 0) ? CH0_RST_VAL : 1'b0)
      ) u_chan (
        .i_clk      (clk[i]),
        .rst        (rst),
        .i_req      (w_req[i]),
        .o_en       (w_en[i]),
        .o_occupied (w_occ[i])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output clock and status
  //
  // Each enable only moves while its own clock is low, so the AND-OR below
  // passes whole high phases of the selected source and nothing else.
  // ---------------------------------------------------------------------------
  assign clk_out   = |(w_en & clk);
  assign active_oh = w_en;

  always_comb begin
    w_active_ext            = '0;
    w_active_ext[N_CLK-1:0] = w_en;
  end

  assign busy = (w_active_ext != w_dec);

endmodule : clk_switch_n
